mc_native_port_arbiter: RTL
===========================

Name: mc_native_port_arbiter

Overview:
- Parametrised N-port native-interface front end for the LPDDR4 memory controller core; replaces the fixed two-port hookup.
- Arbitrates NUM_PORTS native command streams onto the single controller native port.
- Steers write-data bursts from the right requester and returns read-data bursts to the right requester, using in-order port-ID tracking FIFOs.
- Sits between the SoC native masters and the controller core's native port.

Parameters:
NUM_PORTS, 2, number of upstream native ports (1..8)
ADDR_W, 32, native command address width
DATA_W, 256, native data width; multiple of 8
ORDER_DEPTH, 8, entries per order FIFO, i.e. max accepted-but-unfinished writes and reads tracked (power of 2, >=2)

Ports:
clk  in  1  controller clock
rst  in  1  asynchronous active-low reset
s_cmd_valid  in  NUM_PORTS  per-port command valid
s_cmd_ready  out  NUM_PORTS  per-port command ready
s_cmd_we  in  NUM_PORTS  1=write
s_cmd_mw  in  NUM_PORTS  masked write; treated as write for routing
s_cmd_addr  in  NUM_PORTS*ADDR_W  packed addresses, port i at [i*ADDR_W +: ADDR_W]
s_wdata_valid / s_wdata_last  in  NUM_PORTS  write beat valid / last beat
s_wdata_ready  out  NUM_PORTS  write beat ready
s_wdata_data  in  NUM_PORTS*DATA_W  packed write data
s_wdata_we  in  NUM_PORTS*DATA_W/8  packed byte enables
s_rdata_valid / s_rdata_last  out  NUM_PORTS  read beat valid / last beat
s_rdata_ready  in  NUM_PORTS  read beat ready
s_rdata_data  out  DATA_W  read data, broadcast to all ports
m_cmd_valid / m_cmd_we / m_cmd_mw  out  1  to controller
m_cmd_addr  out  ADDR_W  to controller
m_cmd_ready  in  1  from controller
m_wdata_valid / m_wdata_last  out  1  to controller
m_wdata_data  out  DATA_W  to controller
m_wdata_we  out  DATA_W/8  to controller
m_wdata_ready  in  1  from controller
m_rdata_valid / m_rdata_last  in  1  from controller
m_rdata_data  in  DATA_W  from controller
m_rdata_ready  out  1  to controller
rd_underflow  out  1  sticky: read beat arrived with no outstanding read

Behaviour:
- Reset (rst low, async): round-robin pointer=0, grant unlocked, both FIFOs empty, rd_underflow=0; every valid/ready output 0.
- Eligibility: port i is eligible when s_cmd_valid[i]=1 and its target FIFO is not full. Writes (we|mw) target the write FIFO; reads target the read FIFO. A full read FIFO never blocks writes, and vice versa.
- Arbitration: round-robin starting at the pointer; zero-cycle latency, command fields muxed combinationally.
- m_cmd_valid=1 while any port is eligible or a grant is locked.
- Grant lock: when m_cmd_valid=1 and m_cmd_ready=0, the grant and all m_cmd_* outputs stay stable until the handshake.
- s_cmd_ready[i] = m_cmd_ready & grant[i].
- On command handshake: push the granted port ID into the target FIFO (same cycle); pointer = granted+1 mod NUM_PORTS.
- Write path: with the write FIFO non-empty and head port h, m_wdata_* = port h's fields, s_wdata_ready[h]=m_wdata_ready, other ports' ready=0.
  - Pop on a beat handshake with last=1; the next head is served the following cycle.
  - Write FIFO empty: m_wdata_valid=0 and all s_wdata_ready=0. Write data offered before its command is accepted is stalled.
- Read path: with the read FIFO non-empty and head port h, s_rdata_valid[h]=m_rdata_valid and s_rdata_last[h]=m_rdata_last; other ports' valid=0. m_rdata_ready=s_rdata_ready[h].
  - Pop on a beat handshake with last=1.
- Read FIFO empty while m_rdata_valid=1: m_rdata_ready=1, beat dropped, rd_underflow set; it clears only on reset.
- FIFO push and pop in the same cycle: count unchanged; legal even when full.
- Reset mid-burst: all tracking discarded; downstream must be reset together.

Optional Feature:
- Macro: MC_NATIVE_ARB_QOS_EN.
- With the macro: adds input port s_qos, width NUM_PORTS*2.
  - Arbitration picks the highest s_qos among eligible ports; round-robin breaks ties within that level.
  - The pointer still advances to granted+1.
- Without the macro: no s_qos port; pure round-robin.

Decomposition:
- Package mc_native_arb_pkg holds:
  - PORT_ID_W = $clog2(NUM_PORTS) (min 1) as a function;
  - the default ORDER_DEPTH constant;
  - the qos_t typedef (2-bit).
- Sub-module mc_arb_order_fifo: synchronous FIFO of port IDs with full/empty and a count. Instanced twice (write order, read order).

Test Plan:
- NUM_PORTS=2, both ports present reads every cycle, m_cmd_ready=1 -> grants alternate 0,1,0,1; m_cmd_addr matches; read FIFO count tracks.
- Port1 write, then port0 write; port0 offers wdata first -> port0 held (ready=0) until port1's 4-beat burst ends with last; then port0's beats pass.
- Reads from ports 0,1,0; controller returns three 2-beat bursts -> routed to 0,1,0. s_rdata_ready[1]=0 for 3 cycles -> m_rdata_ready=0 for those 3 cycles.
- ORDER_DEPTH=4: 4 reads with no data returned -> 5th read gets no s_cmd_ready, while a concurrent write from the other port is accepted. First read burst completes -> 5th read accepted next cycle.
- m_rdata_valid=1 with no outstanding reads -> m_rdata_ready=1, no s_rdata_valid, rd_underflow=1 and held.
- MC_NATIVE_ARB_QOS_EN, NUM_PORTS=4, s_qos={3,1,3,0}, all valid -> grants 0,2,0,2; ports 1 and 3 are starved until port 0 and port 2 drop valid.

Source files
------------

// File: rtl/mc_native_arb_pkg.sv
// Shared definitions for the N-port native-interface arbiter.
//   port_id_w()          : width of a port ID for a given port count (min 1)
//   DEFAULT_ORDER_DEPTH  : default entries per order-tracking FIFO
//   qos_t                : 2-bit per-port priority (used when MC_NATIVE_ARB_QOS_EN is defined)
package mc_native_arb_pkg;

  localparam int unsigned DEFAULT_ORDER_DEPTH = 8;

  typedef logic [1:0] qos_t;

  function automatic int unsigned port_id_w(input int unsigned num_ports);
    return (num_ports <= 1) ? 1 : $clog2(num_ports);
  endfunction

endpackage

// File: rtl/mc_arb_order_fifo.sv
// In-order FIFO of port IDs used to steer data bursts to the requester whose
// command was accepted first.
//   clk, rst      : clock, asynchronous active-low reset
//   push, push_id : enqueue a port ID
//   pop           : dequeue the head entry
//   head          : current head port ID (valid when !empty)
//   full, empty   : occupancy flags
//   count         : number of stored entries
// Push and pop in the same cycle are legal even when full (count unchanged).
module mc_arb_order_fifo
  import mc_native_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_ORDER_DEPTH,
  parameter int unsigned ID_W  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ID_W-1:0]          push_id,
  input  logic                     pop,
  output logic [ID_W-1:0]          head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // When full, the slot being written is the one being popped this cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/mc_native_port_arbiter.sv
// N-port native-interface front end for the LPDDR4 controller core.
// Arbitrates NUM_PORTS command streams onto the single controller native port
// and steers write/read data bursts using in-order port-ID FIFOs.
//   clk, rst                : controller clock, asynchronous active-low reset
//   s_cmd_*                 : per-port command channel (packed per port)
//   s_wdata_*               : per-port write-data channel
//   s_rdata_*               : per-port read-data channel (data broadcast)
//   m_cmd_*, m_wdata_*,
//   m_rdata_*               : controller-side native port
//   rd_underflow            : sticky, read beat arrived with no outstanding read
// Optional: define MC_NATIVE_ARB_QOS_EN to add s_qos (2 bits per port); the
// highest-QoS eligible port wins, round-robin breaks ties.
module mc_native_port_arbiter
  import mc_native_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 256,
  parameter int unsigned ORDER_DEPTH = DEFAULT_ORDER_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          s_cmd_valid,
  output logic [NUM_PORTS-1:0]          s_cmd_ready,
  input  logic [NUM_PORTS-1:0]          s_cmd_we,
  input  logic [NUM_PORTS-1:0]          s_cmd_mw,
  input  logic [NUM_PORTS*ADDR_W-1:0]   s_cmd_addr,
`ifdef MC_NATIVE_ARB_QOS_EN
  input  logic [NUM_PORTS*2-1:0]        s_qos,
`endif
  input  logic [NUM_PORTS-1:0]          s_wdata_valid,
  input  logic [NUM_PORTS-1:0]          s_wdata_last,
  output logic [NUM_PORTS-1:0]          s_wdata_ready,
  input  logic [NUM_PORTS*DATA_W-1:0]   s_wdata_data,
  input  logic [NUM_PORTS*DATA_W/8-1:0] s_wdata_we,
  output logic [NUM_PORTS-1:0]          s_rdata_valid,
  output logic [NUM_PORTS-1:0]          s_rdata_last,
  input  logic [NUM_PORTS-1:0]          s_rdata_ready,
  output logic [DATA_W-1:0]             s_rdata_data,
  output logic                          m_cmd_valid,
  output logic                          m_cmd_we,
  output logic                          m_cmd_mw,
  output logic [ADDR_W-1:0]             m_cmd_addr,
  input  logic                          m_cmd_ready,
  output logic                          m_wdata_valid,
  output logic                          m_wdata_last,
  output logic [DATA_W-1:0]             m_wdata_data,
  output logic [DATA_W/8-1:0]           m_wdata_we,
  input  logic                          m_wdata_ready,
  input  logic                          m_rdata_valid,
  input  logic                          m_rdata_last,
  input  logic [DATA_W-1:0]             m_rdata_data,
  output logic                          m_rdata_ready,
  output logic                          rd_underflow
);

  localparam int unsigned ID_W  = port_id_w(NUM_PORTS);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(ORDER_DEPTH) + 1;

  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      lock_id;
  logic                 locked;
  logic [ID_W-1:0]      arb_id;
  logic                 arb_found;
  logic [ID_W-1:0]      grant_id;
  logic                 cmd_hs;
  logic                 grant_wr;

  logic [NUM_PORTS-1:0] is_wr;
  logic [NUM_PORTS-1:0] eligible;
  qos_t                 qos [NUM_PORTS];

  logic                 w_push, w_pop, w_full, w_empty;
  logic                 r_push, r_pop, r_full, r_empty;
  logic [ID_W-1:0]      w_head, r_head;
  logic [CNT_W-1:0]     w_count, r_count;

  // ---------------------------------------------------------------- eligibility
  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      is_wr[i]    = s_cmd_we[i] | s_cmd_mw[i];
      eligible[i] = s_cmd_valid[i] & (is_wr[i] ? ~w_full : ~r_full);
`ifdef MC_NATIVE_ARB_QOS_EN
      qos[i]      = s_qos[i*2 +: 2];
`else
      qos[i]      = '0;
`endif
    end
  end

  // ---------------------------------------------------------------- arbiter
  // Find the top QoS level among eligible ports, then round-robin from rr_ptr
  // within that level. Without QoS every level is 0, so this is plain RR.
  always_comb begin
    qos_t            best_qos;
    logic            any_elig;
    logic [ID_W-1:0] cand;
    best_qos  = '0;
    any_elig  = 1'b0;
    arb_found = 1'b0;
    arb_id    = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (eligible[i] && (!any_elig || qos[i] > best_qos)) begin
        best_qos = qos[i];
        any_elig = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = ID_W'((32'(rr_ptr) + k) % NUM_PORTS);
      if (!arb_found && eligible[cand] && qos[cand] == best_qos) begin
        arb_found = 1'b1;
        arb_id    = cand;
      end
    end
  end

  assign grant_id    = locked ? lock_id : arb_id;
  assign m_cmd_valid = rst & (locked | arb_found);
  assign m_cmd_we    = s_cmd_we[grant_id];
  assign m_cmd_mw    = s_cmd_mw[grant_id];
  assign m_cmd_addr  = s_cmd_addr[grant_id*ADDR_W +: ADDR_W];
  assign grant_wr    = is_wr[grant_id];
  assign cmd_hs      = m_cmd_valid & m_cmd_ready;

  always_comb begin
    s_cmd_ready = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      s_cmd_ready[i] = m_cmd_valid & m_cmd_ready & (grant_id == ID_W'(i));
    end
  end

  // Hold the grant while the controller back-pressures an offered command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr  <= '0;
      locked  <= 1'b0;
      lock_id <= '0;
    end else begin
      if (cmd_hs) begin
        locked <= 1'b0;
        rr_ptr <= (grant_id == ID_W'(NUM_PORTS - 1)) ? '0 : grant_id + 1'b1;
      end else if (m_cmd_valid) begin
        locked  <= 1'b1;
        lock_id <= grant_id;
      end
    end
  end

  // ---------------------------------------------------------------- order FIFOs
  assign w_push = cmd_hs & grant_wr;
  assign r_push = cmd_hs & ~grant_wr;

  mc_arb_order_fifo #(
    .DEPTH (ORDER_DEPTH),
    .ID_W  (ID_W)
  ) u_wr_order (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .push_id (grant_id),
    .pop     (w_pop),
    .head    (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  mc_arb_order_fifo #(
    .DEPTH (ORDER_DEPTH),
    .ID_W  (ID_W)
  ) u_rd_order (
    .clk     (clk),
    .rst     (rst),
    .push    (r_push),
    .push_id (grant_id),
    .pop     (r_pop),
    .head    (r_head),
    .full    (r_full),
    .empty   (r_empty),
    .count   (r_count)
  );

  a_order_count_bound: assert property (
    @(posedge clk) disable iff (!rst)
      (w_count <= CNT_W'(ORDER_DEPTH)) && (r_count <= CNT_W'(ORDER_DEPTH)));

  // ---------------------------------------------------------------- write path
  assign m_wdata_valid = rst & ~w_empty & s_wdata_valid[w_head];
  assign m_wdata_last  = ~w_empty & s_wdata_last[w_head];
  assign m_wdata_data  = s_wdata_data[w_head*DATA_W +: DATA_W];
  assign m_wdata_we    = s_wdata_we[w_head*BE_W +: BE_W];
  assign w_pop         = m_wdata_valid & m_wdata_ready & m_wdata_last;

  always_comb begin
    s_wdata_ready = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      s_wdata_ready[i] = rst & ~w_empty & m_wdata_ready & (w_head == ID_W'(i));
    end
  end

  // ---------------------------------------------------------------- read path
  // With nothing outstanding, stray beats are accepted and dropped.
  assign s_rdata_data  = m_rdata_data;
  assign m_rdata_ready = rst & (r_empty ? m_rdata_valid : s_rdata_ready[r_head]);
  assign r_pop         = ~r_empty & m_rdata_valid & s_rdata_ready[r_head] & m_rdata_last;

  always_comb begin
    s_rdata_valid = '0;
    s_rdata_last  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      s_rdata_valid[i] = rst & ~r_empty & m_rdata_valid & (r_head == ID_W'(i));
      s_rdata_last[i]  = ~r_empty & m_rdata_last & (r_head == ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_underflow <= 1'b0;
    end else if (m_rdata_valid && r_empty) begin
      rd_underflow <= 1'b1;
    end
  end

endmodule
